tt_um_alu: RTL and testbench
============================

# tt_um_alu

Registered 4-bit arithmetic/logic unit packaged as a Tiny Tapeout user tile. It takes two 4-bit operands on the dedicated inputs and a 4-bit opcode on the bidirectional inputs, and computes one of 16 operations. Each rising clock edge it registers a 4-bit result plus carry/zero/negative/overflow flags onto the dedicated outputs. It sits directly under the chip harness and has no other sub-blocks above it.

## Interface
- No parameters.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-high reset; the harness name is retained.
- `ena`  input  1  tile enable; when 0, all registers hold.
- `ui_in`  input  8  `[3:0]` = operand A, `[7:4]` = operand B.
- `uio_in`  input  8  `[3:0]` = opcode; `[7:4]` ignored.
- `uo_out`  output  8  `[3:0]` = result R, `[4]` = C, `[5]` = Z, `[6]` = N, `[7]` = V (all registered).
- `uio_out`  output  8  constant 0.
- `uio_oe`  output  8  constant 0 (all bidirectional pins are inputs).

## Operation
- Opcodes, with flag behaviour:
  - 0 ADD: R = A+B. C = carry out. V = signed overflow.
  - 1 SUB: R = A−B. C = 1 when no borrow (A ≥ B unsigned). V = signed overflow.
  - 2 ADC: R = A+B+Creg. C and V as for ADD.
  - 3 SBB: R = A−B−(1−Creg). C and V as for SUB.
  - 4 AND, 5 OR, 6 XOR: bitwise on A and B.
  - 7 NOT: R = ~A.
  - 8 SHL: R = A<<1. C = A[3]. V = A[3]^A[2].
  - 9 SHR: logical right shift. C = A[0].
  - 10 ASR: arithmetic right shift. C = A[0].
  - 11 ROL: rotate A left by 1. C = A[3].
  - 12 ROR: rotate A right by 1. C = A[0].
  - 13 MUL: R = low nibble of A×B (unsigned). C = 1 when the high nibble is nonzero.
  - 14 SLT: R = {3'b0, A<B signed}.
  - 15 PASS: R = B.
- Flag defaults: C = 0 and V = 0 for any operation not listed above as setting them.
- Z = (R == 0) and N = R[3] for every opcode.
- Creg is the registered carry, i.e. `uo_out[4]` from the previous update.
- All arithmetic is 5-bit internally; R is truncated to 4 bits.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on `uo_out` after edge k.
- Reset: `rst_n`=1 at an edge forces `uo_out`=0x00, including Creg=0 and Z=0. Reset has priority over `ena`.
- Reset asserted mid-sequence discards any pending result; an ADC on the first cycle after reset uses Creg=0.
- `ena`=0: `uo_out` and Creg hold their values. ADC/SBB chains resume correctly when `ena` returns to 1.
- Opcode changes between cycles need no handshake; every enabled cycle is an independent operation.

## Configuration
- `ALU_MUL_EN` defined: opcode 13 performs MUL as specified.
- `ALU_MUL_EN` undefined: no multiplier is synthesized. Opcode 13 gives R=0, C=0, N=0, V=0, Z=1.

## Structure
- Package `tt_um_alu_pkg` holds:
  - opcode localparams `OP_ADD` … `OP_PASS`
  - flag bit indices `FLAG_C=4`, `FLAG_Z=5`, `FLAG_N=6`, `FLAG_V=7`
  - operand width constant `W=4`
- Sub-module `alu_core` is purely combinational: inputs A, B, op, cin; outputs R, C, V.
- The top level contains the output register, Z/N derivation, Creg feedback, the `ena`/reset logic and the constant `uio` drives.

## Test plan
- ADD, A=7, B=1 → `uo_out`=0xC8 (R=8, N=1, V=1).
- SUB, A=3, B=5 → `uo_out`=0x4E (R=0xE, C=0, N=1).
- ADD, A=F, B=1 → 0x30. Then ADC, A=0, B=0 → 0x01.
- MUL, A=7, B=3 → 0x15 with `ALU_MUL_EN`, 0x20 without.
- Hold and reset sequence:
  - ADD, A=F, B=1 → 0x30.
  - `ena`=0 with new inputs → stays 0x30.
  - `rst_n`=1 with `ena`=0 → 0x00.
  - After release, ADC, A=1, B=1 → 0x02.
- Sweep all 256 A/B pairs × 16 opcodes against a reference model. Check `uio_oe`=`uio_out`=0 throughout.

Source files
------------

// File: rtl/tt_um_alu_pkg.sv
// Shared constants for the tt_um_alu tile: operand width, opcodes and flag bit positions.
// Optional multiplier is controlled by the ALU_MUL_EN macro (see alu_core).
package tt_um_alu_pkg;

  localparam int W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SBB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_SLT  = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 5;
  localparam int FLAG_N = 6;
  localparam int FLAG_V = 7;

endpackage

// File: rtl/tt_um_alu_core.sv
// Combinational 4-bit ALU datapath: result plus carry and overflow.
// With ALU_MUL_EN defined, opcode 13 multiplies; otherwise it yields zero.
module alu_core
  import tt_um_alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  input  logic         cin,
  output logic [W-1:0] r,
  output logic         c,
  output logic         v
);

  logic [W:0]   sum;
  logic [W-1:0] b_inv;
`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod;
`endif

  assign b_inv = ~b;

  always_comb begin
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    sum = '0;
`ifdef ALU_MUL_EN
    prod = '0;
`endif
    case (op)
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == OP_ADC) & cin};
        r   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      // Subtract as A + ~B + carry-in so the carry out is the "no borrow" flag.
      OP_SUB, OP_SBB: begin
        sum = {1'b0, a} + {1'b0, b_inv} + {{W{1'b0}}, (op == OP_SUB) | cin};
        r   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b_inv[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        r = {a[W-2:0], 1'b0};
        c = a[W-1];
        v = a[W-1] ^ a[W-2];
      end
      OP_SHR: begin
        r = {1'b0, a[W-1:1]};
        c = a[0];
      end
      OP_ASR: begin
        r = {a[W-1], a[W-1:1]};
        c = a[0];
      end
      OP_ROL: begin
        r = {a[W-2:0], a[W-1]};
        c = a[W-1];
      end
      OP_ROR: begin
        r = {a[0], a[W-1:1]};
        c = a[0];
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r    = prod[W-1:0];
        c    = |prod[2*W-1:W];
`else
        r = '0;
`endif
      end
      OP_SLT:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASS: r = b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/tt_um_alu.sv
// Tiny Tapeout tile wrapper: registers ALU result and C/Z/N/V flags, feeds carry back for ADC/SBB.
// Multiplier on opcode 13 is present only when ALU_MUL_EN is defined.
module tt_um_alu
  import tt_um_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]   out_reg;
  logic [7:0]   out_next;
  logic [W-1:0] core_r;
  logic         core_c;
  logic         core_v;
  logic         unused_bits;

  // rst_n keeps its harness name but is an active-high synchronous reset.
  alu_core u_core (
    .a   (ui_in[W-1:0]),
    .b   (ui_in[2*W-1:W]),
    .op  (uio_in[3:0]),
    .cin (out_reg[FLAG_C]),
    .r   (core_r),
    .c   (core_c),
    .v   (core_v)
  );

  always_comb begin
    out_next          = '0;
    out_next[W-1:0]   = core_r;
    out_next[FLAG_C]  = core_c;
    out_next[FLAG_Z]  = (core_r == '0);
    out_next[FLAG_N]  = core_r[W-1];
    out_next[FLAG_V]  = core_v;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_reg <= '0;
    end else if (ena) begin
      out_reg <= out_next;
    end
  end

  assign uo_out      = out_reg;
  assign uio_out     = '0;
  assign uio_oe      = '0;
  assign unused_bits = &{1'b0, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_alu.sv
// Randomized self-checking bench for tt_um_alu against an integer-arithmetic reference model.
module tb_tt_um_alu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [7:0] model_out = 8'h00;

  tt_um_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference: plain integer arithmetic from the opcode table.
  function automatic logic [7:0] ref_alu(input int a, input int b, input int op, input int creg);
    int res, c, v, s, sa, sb, p;
    res = 0; c = 0; v = 0;
    sa = to_signed4(a);
    sb = to_signed4(b);
    case (op)
      0, 2: begin
        s = a + b + ((op == 2) ? creg : 0);
        res = s % 16;
        c = (s > 15) ? 1 : 0;
        p = sa + sb + ((op == 2) ? creg : 0);
        v = (p > 7 || p < -8) ? 1 : 0;
      end
      1, 3: begin
        s = a - b - ((op == 3) ? (1 - creg) : 0);
        res = (s + 32) % 16;
        c = (s >= 0) ? 1 : 0;
        p = sa - sb - ((op == 3) ? (1 - creg) : 0);
        v = (p > 7 || p < -8) ? 1 : 0;
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = 15 - a;
      8: begin
        res = (a * 2) % 16;
        c = a / 8;
        v = ((a / 8) != ((a / 4) % 2)) ? 1 : 0;
      end
      9:  begin res = a / 2; c = a % 2; end
      10: begin res = (sa >>> 1) & 15; c = a % 2; end
      11: begin res = ((a * 2) % 16) + a / 8; c = a / 8; end
      12: begin res = a / 2 + (a % 2) * 8; c = a % 2; end
      13: begin
`ifdef ALU_MUL_EN
        p = a * b;
        res = p % 16;
        c = (p > 15) ? 1 : 0;
`endif
      end
      14: res = (sa < sb) ? 1 : 0;
      default: res = b;
    endcase
    return {v[0], (res >= 8) ? 1'b1 : 1'b0, (res == 0) ? 1'b1 : 1'b0, c[0], res[3:0]};
  endfunction

  task automatic step(input logic e, input logic r, input int a, input int b, input int op);
    @(negedge clk);
    ena    = e;
    rst_n  = r;
    ui_in  = {b[3:0], a[3:0]};
    uio_in = {4'($urandom_range(0, 15)), op[3:0]};
    @(posedge clk);
    #1;
    if (r) model_out = 8'h00;
    else if (e) model_out = ref_alu(a, b, op, int'(model_out[4]));
    $display("txn ena=%0d rst=%0d op=%0d a=%0h b=%0h uo_out=%02h", e, r, op, a, b, uo_out);
    check("uo_out", {8'h00, uo_out}, {8'h00, model_out});
    check("uio", {uio_oe, uio_out}, 16'h0000);
  endtask

  logic [7:0] mul_exp;

  initial begin
    ena = 1'b0; rst_n = 1'b1; ui_in = '0; uio_in = '0;
`ifdef ALU_MUL_EN
    mul_exp = 8'h15;
`else
    mul_exp = 8'h20;
`endif
    step(1'b1, 1'b1, 0, 0, 0);
    check("reset", {8'h00, uo_out}, 16'h0000);

    step(1'b1, 1'b0, 7, 1, 0);   check("add_7_1", {8'h00, uo_out}, 16'h00C8);
    step(1'b1, 1'b0, 3, 5, 1);   check("sub_3_5", {8'h00, uo_out}, 16'h004E);
    step(1'b1, 1'b0, 15, 1, 0);  check("add_f_1", {8'h00, uo_out}, 16'h0030);
    step(1'b1, 1'b0, 0, 0, 2);   check("adc_0_0", {8'h00, uo_out}, 16'h0001);
    step(1'b1, 1'b0, 7, 3, 13);  check("mul_7_3", {8'h00, uo_out}, {8'h00, mul_exp});

    step(1'b1, 1'b0, 15, 1, 0);  check("hold_pre", {8'h00, uo_out}, 16'h0030);
    step(1'b0, 1'b0, 2, 9, 6);   check("hold", {8'h00, uo_out}, 16'h0030);
    step(1'b0, 1'b1, 4, 4, 0);   check("rst_no_ena", {8'h00, uo_out}, 16'h0000);
    step(1'b1, 1'b0, 1, 1, 2);   check("adc_after_rst", {8'h00, uo_out}, 16'h0002);

    // Carry chain interrupted by a disabled cycle.
    step(1'b1, 1'b0, 15, 15, 0);
    step(1'b0, 1'b0, 0, 0, 1);
    step(1'b1, 1'b0, 0, 0, 2);   check("adc_resume", {8'h00, uo_out}, 16'h0001);

    for (int op = 0; op < 16; op++)
      for (int ab = 0; ab < 256; ab++)
        step(1'b1, 1'b0, ab % 16, ab / 16, op);

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
